mux16_rr_sched: RTL and testbench

Round-robin scheduler that shares the 16:1 8-bit selector mux among 16 requesters. It watches a 16-bit request vector and picks one winner at a time, fair across requesters. It drives the mux select, acknowledges the winner with a one-cycle grant, and registers the mux output. The result is presented to the downstream ALU stage through a valid/ready handshake. It sits between the 16 operand sources, the mux, and the ALU operand register.

---
 rtl/mux16_rr_sched.sv | 133 +++++++++++++
 tb/tb_mux16_rr_sched.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler sharing a 16:1 DW-bit mux among 16 requesters.
// Grants one winner at a time, captures the mux output, and hands it downstream over valid/ready.
module mux16_rr_sched #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   req,
  input  logic [DW-1:0] mux_out,
  output logic [3:0]    sel,
  output logic [15:0]   gnt,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    ptr_q, ptr_d;
  logic [3:0]    sel_q, sel_d;
  logic [15:0]   gnt_q, gnt_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          busy_s;

  logic [31:0]   req_dbl_s;
  logic [15:0]   req_rot_s;
  logic [3:0]    winner_s;

  function automatic logic [3:0] first_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = i[3:0];
    end
    return idx;
  endfunction

  // Rotate so bit 0 is the ptr position; the first set bit is the offset from ptr.
  always_comb begin
    req_dbl_s = {req, req};
    req_rot_s = req_dbl_s[ptr_q +: 16];
    winner_s  = ptr_q + first_set(req_rot_s);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req != 16'd0) state_d = LOAD;
        else              state_d = IDLE;
      end
      LOAD: state_d = HOLD;
      HOLD: begin
        if (dout_ready) state_d = IDLE;
        else            state_d = HOLD;
      end
      default: state_d = IDLE;
    endcase
  end

  // gnt defaults to zero every cycle, which is what makes it a single-cycle pulse.
  always_comb begin
    sel_d        = sel_q;
    gnt_d        = 16'd0;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    ptr_d        = ptr_q;
    busy_s       = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (req != 16'd0) begin
          sel_d = winner_s;
          gnt_d = 16'd1 << winner_s;
        end else begin
          sel_d = sel_q;
        end
      end
      LOAD: begin
        dout_d       = mux_out;
        dout_valid_d = 1'b1;
      end
      HOLD: begin
        if (dout_ready) begin
          dout_valid_d = 1'b0;
          ptr_d        = sel_q + 4'd1;
        end else begin
          dout_valid_d = dout_valid_q;
        end
      end
      default: begin
        gnt_d = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q        <= 4'd0;
      gnt_q        <= 16'd0;
      dout_q       <= {DW{1'b0}};
      dout_valid_q <= 1'b0;
      ptr_q        <= 4'd0;
    end else begin
      sel_q        <= sel_d;
      gnt_q        <= gnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      ptr_q        <= ptr_d;
    end
  end

  assign sel        = sel_q;
  assign gnt        = gnt_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_s;

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Scoreboard bench for mux16_rr_sched: stimulus pushes expected grants/results,
// a negedge monitor pops and compares on every gnt pulse and every dout handshake.
module tb_mux16_rr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic [7:0]  mux_out;
  logic [3:0]  sel;
  logic [15:0] gnt;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        busy;

  logic        mux_mode;
  logic [7:0]  mux_fixed;

  int errors = 0;
  int checks = 0;
  int hs_count = 0;
  int exp_sel_q[$];
  int exp_dout_q[$];
  int exp_dsel_q[$];

  mux16_rr_sched #(.DW(8)) dut (
    .clk(clk), .rst(rst), .req(req), .mux_out(mux_out),
    .sel(sel), .gnt(gnt), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Bench model of the external mux.
  always_comb mux_out = mux_mode ? {sel, 4'h0} : mux_fixed;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [15:0] r, input int s, input int d);
    exp_sel_q.push_back(s);
    exp_dout_q.push_back(d);
    exp_dsel_q.push_back(s);
    req = r;
    tick();
    req = 16'h0000;
    tick();
    tick();
  endtask

  // Monitor: every gnt pulse and every accepted result is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (gnt != 16'h0000) begin
        if (exp_sel_q.size() == 0) begin
          check("gnt_unexpected", int'(gnt), 0);
        end else begin
          int e;
          e = exp_sel_q.pop_front();
          check("gnt_onehot", int'(gnt), 1 << e);
          check("gnt_sel", int'(sel), e);
        end
      end
      if (dout_valid && dout_ready) begin
        hs_count++;
        if (exp_dout_q.size() == 0) begin
          check("dout_unexpected", int'(dout), -1);
        end else begin
          int d;
          int s;
          d = exp_dout_q.pop_front();
          s = exp_dsel_q.pop_front();
          check("dout_data", int'(dout), d);
          check("dout_sel", int'(sel), s);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1; req = 16'h0000; dout_ready = 1'b0;
    mux_mode = 1'b0; mux_fixed = 8'h00;
    tick(); tick();
    check("rst_sel", int'(sel), 0);
    check("rst_gnt", int'(gnt), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_valid", int'(dout_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ptr", int'(dut.ptr_q), 0);
    rst = 1'b0;

    // Single request
    mux_fixed = 8'hA5; dout_ready = 1'b1;
    exp_sel_q.push_back(5); exp_dout_q.push_back(8'hA5); exp_dsel_q.push_back(5);
    req = 16'h0020;
    tick();
    check("t1_busy_load", int'(busy), 1);
    req = 16'h0000;
    tick();
    check("t1_dout", int'(dout), 8'hA5);
    check("t1_valid", int'(dout_valid), 1);
    tick();
    check("t1_ptr", int'(dut.ptr_q), 6);
    check("t1_busy_idle", int'(busy), 0);

    // Round-robin fairness from ptr=0
    rst = 1'b1; tick(); rst = 1'b0;
    mux_mode = 1'b1;
    for (int k = 0; k < 17; k++) begin
      exp_sel_q.push_back(k % 16);
      exp_dout_q.push_back((k % 16) * 16);
      exp_dsel_q.push_back(k % 16);
    end
    base = hs_count;
    req = 16'hFFFF;
    for (int k = 0; k < 17; k++) begin
      repeat (3) tick();
      check("rr_cadence", hs_count, base + k + 1);
    end
    req = 16'h0000;
    tick();
    check("rr_ptr", int'(dut.ptr_q), 1);

    // Wrap and skip
    xfer(16'h2000, 13, 8'hD0);
    check("wrap_ptr14", int'(dut.ptr_q), 14);
    xfer(16'h0009, 0, 8'h00);
    check("wrap_ptr1", int'(dut.ptr_q), 1);
    xfer(16'h0008, 3, 8'h30);
    check("skip_ptr4", int'(dut.ptr_q), 4);

    // Backpressure
    mux_mode = 1'b0; mux_fixed = 8'h3C; dout_ready = 1'b0;
    exp_sel_q.push_back(8); exp_dout_q.push_back(8'h3C); exp_dsel_q.push_back(8);
    req = 16'h0102;
    tick();
    req = 16'h0002;
    tick();
    check("bp_valid0", int'(dout_valid), 1);
    for (int k = 0; k < 5; k++) begin
      mux_fixed = ~mux_fixed;
      tick();
      check("bp_valid", int'(dout_valid), 1);
      check("bp_dout", int'(dout), 8'h3C);
      check("bp_sel", int'(sel), 8);
      check("bp_gnt", int'(gnt), 0);
    end
    dout_ready = 1'b1;
    exp_sel_q.push_back(1); exp_dout_q.push_back(8'hC3); exp_dsel_q.push_back(1);
    tick();
    check("bp_no_early_gnt", int'(gnt), 0);
    check("bp_idle", int'(busy), 0);
    tick();
    check("bp_gnt_after", int'(gnt), 16'h0002);
    req = 16'h0000;
    tick(); tick();
    check("bp_ptr", int'(dut.ptr_q), 2);

    // Request withdrawn after one cycle
    mux_fixed = 8'h5A;
    xfer(16'h8000, 15, 8'h5A);
    check("wd_ptr", int'(dut.ptr_q), 0);

    // Mid-operation reset in HOLD
    mux_fixed = 8'h77;
    xfer(16'h0010, 4, 8'h77);
    check("mr_ptr5", int'(dut.ptr_q), 5);
    dout_ready = 1'b0;
    exp_sel_q.push_back(6);
    req = 16'h0040;
    tick();
    req = 16'h0000;
    tick();
    check("mr_hold_valid", int'(dout_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_valid", int'(dout_valid), 0);
    check("mr_dout", int'(dout), 0);
    check("mr_sel", int'(sel), 0);
    check("mr_gnt", int'(gnt), 0);
    check("mr_busy", int'(busy), 0);
    dout_ready = 1'b1;
    xfer(16'h0021, 0, 8'h77);
    check("mr_ptr_after", int'(dut.ptr_q), 1);

    tick();
    check("sb_gnt_empty", exp_sel_q.size(), 0);
    check("sb_dout_empty", exp_dout_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
